// File: rtl/mem_if_pkg.sv
// Shared definitions for the core memory interface: load/store encodings
// and the controller FSM states.
package mem_if_pkg;

  localparam logic [2:0] LB    = 3'd0;
  localparam logic [2:0] LH    = 3'd1;
  localparam logic [2:0] LW    = 3'd2;
  localparam logic [2:0] LBU   = 3'd4;
  localparam logic [2:0] LHU   = 3'd5;
  localparam logic [2:0] LNONE = 3'd7;

  localparam logic [1:0] SB    = 2'd0;
  localparam logic [1:0] SH    = 2'd1;
  localparam logic [1:0] SW    = 2'd2;
  localparam logic [1:0] SNONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_REQ  = 2'd1,
    RD_REQ  = 2'd2,
    RD_WAIT = 2'd3
  } state_e;

endpackage

// File: rtl/mem_if_if.sv
// Word-addressed system bus between the memory interface (master) and memory.
// Handshake: a request transfers in a cycle where bus_req=1 and bus_gnt=1; the
// master holds bus_req and all request fields stable until then. A read answers
// with a single bus_rvalid pulse (data on bus_rdata) no earlier than the next cycle.
interface mem_if_if;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_align.sv
// Combinational lane logic: load byte/halfword extraction with extension, and
// store data replication plus byte strobes. Misaligned offsets are truncated.
module mem_align
  import mem_if_pkg::*;
(
  input  logic [2:0]  ld_op_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o,
  input  logic [1:0]  st_op_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_data_o,
  output logic [3:0]  st_strb_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = ld_word_i[7:0];
    case (ld_off_i)
      2'd0:    byte_sel = ld_word_i[7:0];
      2'd1:    byte_sel = ld_word_i[15:8];
      2'd2:    byte_sel = ld_word_i[23:16];
      default: byte_sel = ld_word_i[31:24];
    endcase
    half_sel = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
  end

  always_comb begin
    ld_data_o = ld_word_i;
    case (ld_op_i)
      LB:      ld_data_o = {{24{byte_sel[7]}}, byte_sel};
      LH:      ld_data_o = {{16{half_sel[15]}}, half_sel};
      LBU:     ld_data_o = {24'h0, byte_sel};
      LHU:     ld_data_o = {16'h0, half_sel};
      LW:      ld_data_o = ld_word_i;
      default: ld_data_o = ld_word_i;
    endcase
  end

  // Data is replicated into every lane so the strobe alone picks the target bytes.
  always_comb begin
    st_data_o = st_data_i;
    st_strb_o = 4'b0000;
    case (st_op_i)
      SB: begin
        st_data_o = {4{st_data_i[7:0]}};
        st_strb_o = 4'b0001 << st_off_i;
      end
      SH: begin
        st_data_o = {2{st_data_i[15:0]}};
        st_strb_o = st_off_i[1] ? 4'b1100 : 4'b0011;
      end
      SW: begin
        st_data_o = st_data_i;
        st_strb_o = 4'b1111;
      end
      default: begin
        st_data_o = st_data_i;
        st_strb_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_if.sv
// Core-side load/store unit: posted one-entry write buffer, single outstanding
// read, and a req/gnt + rvalid system bus. FSM state is exported on state_o.
module mem_if
  import mem_if_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic [31:0]  mem_addr,
  input  logic [2:0]   mem_read_op,
  input  logic [1:0]   mem_write_op,
  input  logic         mem_init,
  input  logic [31:0]  mem_wdata,
  output logic         mem_ready,
  output logic [31:0]  mem_rdata,
  mem_if_if.master     bus,
  output state_e       state_o
);

  state_e      state_q, state_d;
  logic [29:0] wr_addr_q;
  logic [31:0] wr_data_q;
  logic [3:0]  wr_strb_q;
  logic        rd_pend_q, rd_pend_d;
  logic [2:0]  rd_op_q;
  logic [31:0] rd_addr_q;
  logic        ready_q;
  logic [31:0] rdata_q;

  logic        wr_load, rd_load, rd_done;
  logic [31:0] ld_data, st_data;
  logic [3:0]  st_strb;

  logic        req_c, we_c;
  logic [29:0] addr_c;
  logic [31:0] wdata_c;
  logic [3:0]  wstrb_c;

  mem_align u_align (
    .ld_op_i   (rd_op_q),
    .ld_off_i  (rd_addr_q[1:0]),
    .ld_word_i (bus.bus_rdata),
    .ld_data_o (ld_data),
    .st_op_i   (mem_write_op),
    .st_off_i  (mem_addr[1:0]),
    .st_data_i (mem_wdata),
    .st_data_o (st_data),
    .st_strb_o (st_strb)
  );

  always_comb begin
    state_d   = state_q;
    rd_pend_d = rd_pend_q;
    wr_load   = 1'b0;
    rd_load   = 1'b0;
    rd_done   = 1'b0;
    req_c     = 1'b0;
    we_c      = 1'b0;
    addr_c    = rd_addr_q[31:2];
    wdata_c   = wr_data_q;
    wstrb_c   = 4'b0000;
    case (state_q)
      IDLE: begin
        if (mem_write_op != SNONE) begin
          wr_load = 1'b1;
          state_d = WR_REQ;
          if (mem_init) begin
            rd_load   = 1'b1;
            rd_pend_d = 1'b1;
          end
        end else if (mem_init) begin
          rd_load = 1'b1;
          state_d = RD_REQ;
        end
      end
      WR_REQ: begin
        req_c   = 1'b1;
        we_c    = 1'b1;
        addr_c  = wr_addr_q;
        wstrb_c = wr_strb_q;
        if (mem_init) begin
          rd_load   = 1'b1;
          rd_pend_d = 1'b1;
        end
        // A read arriving in the grant cycle itself still follows the write.
        if (bus.bus_gnt) begin
          state_d   = (rd_pend_q || mem_init) ? RD_REQ : IDLE;
          rd_pend_d = 1'b0;
        end
      end
      RD_REQ: begin
        req_c = 1'b1;
        if (bus.bus_gnt) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.bus_rvalid) begin
          rd_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      rd_pend_q <= 1'b0;
      rd_op_q   <= LNONE;
      rd_addr_q <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
      if (wr_load) begin
        wr_addr_q <= mem_addr[31:2];
        wr_data_q <= st_data;
        wr_strb_q <= st_strb;
      end
      if (rd_load) begin
        rd_op_q   <= mem_read_op;
        rd_addr_q <= mem_addr;
        ready_q   <= 1'b0;
      end
      if (rd_done) begin
        ready_q <= 1'b1;
        rdata_q <= ld_data;
      end
    end
  end

  assign bus.bus_req   = req_c;
  assign bus.bus_we    = we_c;
  assign bus.bus_addr  = addr_c;
  assign bus.bus_wdata = wdata_c;
  assign bus.bus_wstrb = wstrb_c;
  assign mem_ready     = ready_q;
  assign mem_rdata     = rdata_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_mem_if.sv
// Directed bench for mem_if: a bus-slave model, core-side driver tasks and a
// scoreboard of expected load results, read addresses and write beats.
module tb_mem_if;
  import mem_if_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [2:0]  mem_read_op = LNONE;
  logic [1:0]  mem_write_op = SNONE;
  logic        mem_init = 1'b0;
  logic [31:0] mem_wdata = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  state_e      state;

  mem_if_if bus ();

  mem_if dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_addr     (mem_addr),
    .mem_read_op  (mem_read_op),
    .mem_write_op (mem_write_op),
    .mem_init     (mem_init),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .bus          (bus),
    .state_o      (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time got limit required finish earlier");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] rd_exp_q[$];
  logic [29:0] rdaddr_exp_q[$];
  logic [65:0] wr_exp_q[$];

  logic [31:0] rd_word = '0;
  int          gnt_delay = 0;
  int          rv_lat = 1;
  logic        inject_rv = 1'b0;
  logic        ready_prev = 1'b0;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input int got, input int req);
    checks++;
    errors++;
    $display("FAIL %s: event count got %0d required %0d", name, got, req);
  endtask

  // ---------------- bus slave model ----------------
  initial begin : slave
    int waited;
    int rv_cnt;
    waited = 0;
    rv_cnt = 0;
    bus.bus_gnt    = 1'b0;
    bus.bus_rvalid = 1'b0;
    bus.bus_rdata  = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.bus_rvalid = inject_rv;
      bus.bus_rdata  = rd_word;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) bus.bus_rvalid = 1'b1;
      end
      bus.bus_gnt = 1'b0;
      if (bus.bus_req) begin
        if (waited >= gnt_delay) begin
          bus.bus_gnt = 1'b1;
          waited = 0;
          if (!bus.bus_we) rv_cnt = rv_lat;
        end else begin
          waited++;
        end
      end else begin
        waited = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_ready && !ready_prev) begin
        if (rd_exp_q.size() == 0) fail("unexpected_ready", 1, 0);
        else check("load_data", 66'(mem_rdata), 66'(rd_exp_q.pop_front()));
      end
      if (bus.bus_req && bus.bus_gnt) begin
        if (bus.bus_we) begin
          if (wr_exp_q.size() == 0) fail("unexpected_write", 1, 0);
          else check("write_beat", {bus.bus_addr, bus.bus_wdata, bus.bus_wstrb},
                     wr_exp_q.pop_front());
        end else begin
          if (rdaddr_exp_q.size() == 0) fail("unexpected_read", 1, 0);
          else check("read_addr", 66'(bus.bus_addr), 66'(rdaddr_exp_q.pop_front()));
          check("read_strb", 66'(bus.bus_wstrb), 66'(0));
          check("write_before_read", 66'(wr_exp_q.size()), 66'(0));
        end
      end
      if (state == IDLE || state == RD_WAIT)
        check("no_req_idle_wait", 66'(bus.bus_req), 66'(0));
    end
    ready_prev = mem_ready;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] word, input logic [31:0] exp,
                         input bit expect_data);
    rd_word = word;
    rdaddr_exp_q.push_back(addr[31:2]);
    if (expect_data) rd_exp_q.push_back(exp);
    mem_init    = 1'b1;
    mem_read_op = op;
    mem_addr    = addr;
    tick();
    mem_init    = 1'b0;
    mem_read_op = LNONE;
  endtask

  task automatic do_store(input logic [1:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [29:0] exp_waddr,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_strb);
    wr_exp_q.push_back({exp_waddr, exp_wdata, exp_strb});
    mem_write_op = op;
    mem_addr     = addr;
    mem_wdata    = data;
    tick();
    mem_write_op = SNONE;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 30; i++) begin
      if (mem_ready) return;
      tick();
    end
    fail(name, 0, 1);
  endtask

  task automatic wait_wr_done(input string name);
    for (int i = 0; i < 30; i++) begin
      if (state == IDLE && wr_exp_q.size() == 0) return;
      tick();
    end
    fail(name, 0, 1);
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] word;
    logic [31:0] exp;
  } ld_vec_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } st_vec_t;

  ld_vec_t ldv[$];
  st_vec_t stv[$];

  // ---------------- test sequence ----------------
  initial begin
    ldv.push_back('{LB,  32'h0000_0103, 32'h8011_2233, 32'hFFFF_FF80});
    ldv.push_back('{LBU, 32'h0000_0103, 32'h8011_2233, 32'h0000_0080});
    ldv.push_back('{LH,  32'h0000_0102, 32'h8011_2233, 32'hFFFF_8011});
    ldv.push_back('{LHU, 32'h0000_0103, 32'h8011_2233, 32'h0000_8011});
    ldv.push_back('{LH,  32'h0000_0100, 32'h8011_2233, 32'h0000_2233});
    ldv.push_back('{LB,  32'h0000_0101, 32'h8011_2233, 32'h0000_0022});
    ldv.push_back('{LBU, 32'h0000_0102, 32'h00FE_0000, 32'h0000_00FE});
    ldv.push_back('{LW,  32'h0000_0103, 32'h8011_2233, 32'h8011_2233});
    ldv.push_back('{LH,  32'h0000_0000, 32'h0000_F00F, 32'hFFFF_F00F});

    stv.push_back('{SH, 32'h0000_0202, 32'h1234_ABCD, 30'h80,  32'hABCD_ABCD, 4'b1100});
    stv.push_back('{SB, 32'h0000_0301, 32'h0000_00A5, 30'hC0,  32'hA5A5_A5A5, 4'b0010});
    stv.push_back('{SB, 32'h0000_0303, 32'hFFFF_FF5A, 30'hC0,  32'h5A5A_5A5A, 4'b1000});
    stv.push_back('{SW, 32'h0000_0403, 32'hCAFE_F00D, 30'h100, 32'hCAFE_F00D, 4'b1111});
    stv.push_back('{SH, 32'h0000_0201, 32'h0000_7E81, 30'h80,  32'h7E81_7E81, 4'b0011});
    stv.push_back('{SB, 32'h0000_0000, 32'h0000_0012, 30'h0,   32'h1212_1212, 4'b0001});

    // Reset state
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_ready", 66'(mem_ready), 66'(0));
    check("rst_rdata", 66'(mem_rdata), 66'(0));
    check("rst_bus_req", 66'(bus.bus_req), 66'(0));
    check("rst_state", 66'(state), 66'(IDLE));
    reset_n = 1'b1;
    tick();

    // LW at 0x100: ready exactly two edges after the mem_init edge
    do_load(LW, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    tick();
    check("lat_e1_ready", 66'(mem_ready), 66'(0));
    tick();
    check("lat_e2_ready", 66'(mem_ready), 66'(1));
    check("lat_e2_rdata", 66'(mem_rdata), 66'(32'hDEAD_BEEF));

    // Result holds; stray rvalid in IDLE is ignored
    rd_word   = 32'h0123_4567;
    inject_rv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_ready", 66'(mem_ready), 66'(1));
      check("hold_rdata", 66'(mem_rdata), 66'(32'hDEAD_BEEF));
    end
    inject_rv = 1'b0;
    tick();

    // Load extraction vectors
    foreach (ldv[i]) begin
      do_load(ldv[i].op, ldv[i].addr, ldv[i].word, ldv[i].exp, 1'b1);
      wait_ready("load_timeout");
      tick();
    end

    // Store lane placement vectors; ready/rdata untouched by writes
    foreach (stv[i]) begin
      do_store(stv[i].op, stv[i].addr, stv[i].data, stv[i].waddr, stv[i].wdata, stv[i].strb);
      wait_wr_done("store_timeout");
    end
    check("ready_kept_after_writes", 66'(mem_ready), 66'(1));
    check("rdata_kept_after_writes", 66'(mem_rdata), 66'(32'hFFFF_F00F));

    // SW then mem_init next cycle with a slow grant; a store during WR_REQ is dropped
    gnt_delay = 3;
    do_store(SW, 32'h0000_0500, 32'h1122_3344, 30'h140, 32'h1122_3344, 4'b1111);
    rd_word     = 32'h5566_7788;
    rdaddr_exp_q.push_back(30'h180);
    rd_exp_q.push_back(32'h5566_7788);
    mem_init    = 1'b1;
    mem_read_op = LW;
    mem_addr    = 32'h0000_0600;
    tick();
    mem_init     = 1'b0;
    mem_read_op  = LNONE;
    mem_write_op = SB;
    mem_addr     = 32'h0000_0700;
    mem_wdata    = 32'h0000_00EE;
    check("pend_state_wr", 66'(state), 66'(WR_REQ));
    check("pend_ready_low", 66'(mem_ready), 66'(0));
    tick();
    mem_write_op = SNONE;
    for (int i = 0; i < 10 && state == WR_REQ; i++) begin
      check("wr_ready_low", 66'(mem_ready), 66'(0));
      tick();
    end
    check("after_wr_state", 66'(state), 66'(RD_REQ));
    wait_ready("pend_read_timeout");
    tick();

    // mem_init in RD_REQ is ignored
    gnt_delay = 2;
    do_load(LW, 32'h0000_0700, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1);
    mem_init    = 1'b1;
    mem_read_op = LB;
    mem_addr    = 32'h0000_07FF;
    tick();
    mem_init    = 1'b0;
    mem_read_op = LNONE;
    check("init_ignored_state", 66'(state), 66'(RD_REQ));
    wait_ready("ign_init_timeout");
    tick();
    gnt_delay = 0;

    // Reset in RD_WAIT, late rvalid afterwards
    rv_lat = 3;
    do_load(LW, 32'h0000_0800, 32'h7777_7777, 32'h0, 1'b0);
    tick();
    check("pre_rst_state", 66'(state), 66'(RD_WAIT));
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_rst_state", 66'(state), 66'(IDLE));
    check("mid_rst_ready", 66'(mem_ready), 66'(0));
    check("mid_rst_rdata", 66'(mem_rdata), 66'(0));
    check("mid_rst_req", 66'(bus.bus_req), 66'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("late_rv_ready", 66'(mem_ready), 66'(0));
      check("late_rv_state", 66'(state), 66'(IDLE));
    end
    rv_lat = 1;

    tick();
    check("rd_queue_empty", 66'(rd_exp_q.size()), 66'(0));
    check("rdaddr_queue_empty", 66'(rdaddr_exp_q.size()), 66'(0));
    check("wr_queue_empty", 66'(wr_exp_q.size()), 66'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_if.md
MEM_IF -- requirements
Module: mem_if

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset_n, input, 1 bit: reset is synchronous and active-low.
REQ-003 SHALL have port mem_addr, input, 32 bits: byte address from the core's address mux.
REQ-004 SHALL have port mem_read_op, input, 3 bits: load encoding LB=0, LH=1, LW=2, LBU=4, LHU=5, LNONE=7.
REQ-005 SHALL have port mem_write_op, input, 2 bits: store encoding SB=0, SH=1, SW=2, SNONE=3.
REQ-006 SHALL have port mem_init, input, 1 bit: one-cycle pulse that starts a read.
REQ-007 SHALL have port mem_wdata, input, 32 bits: store data, right-aligned (rs2).
REQ-008 SHALL have port mem_ready, output, 1 bit: read data valid for the most recent mem_init.
REQ-009 SHALL have port mem_rdata, output, 32 bits: aligned and extended load result.
REQ-010 SHALL have port bus_req, output, 1 bit: bus request, held until granted.
REQ-011 SHALL have ports bus_we (output, 1 bit), bus_addr (output, 30 bits: word address), bus_wdata (output, 32 bits) and bus_wstrb (output, 4 bits).
REQ-012 SHALL have port bus_gnt, input, 1 bit: the request is accepted in a cycle where bus_req=1 and bus_gnt=1.
REQ-013 SHALL have ports bus_rvalid (input, 1 bit) and bus_rdata (input, 32 bits): read response, arriving no earlier than the cycle after the grant.

Function
REQ-014 The FSM SHALL have states IDLE, WR_REQ, RD_REQ and RD_WAIT.
REQ-015 In IDLE, mem_write_op != SNONE SHALL capture address, lane-shifted data and strobe into a one-entry write buffer, then go to WR_REQ; the core does not wait on writes.
REQ-016 Strobes: SB = 1 << addr[1:0]; SH = 0011 if addr[1]=0, else 1100; SW = 1111. Data is replicated across lanes.
REQ-017 mem_init=1 SHALL latch mem_read_op and mem_addr, clear mem_ready on the next edge, and go to RD_REQ; from WR_REQ it SHALL be held pending.
REQ-018 WR_REQ SHALL drive bus_req=1 and bus_we=1 until the grant; it then goes to RD_REQ if a read is pending, otherwise to IDLE.
REQ-019 RD_REQ SHALL drive bus_req=1, bus_we=0 and bus_wstrb=0000 until the grant, then go to RD_WAIT.
REQ-020 On bus_rvalid in RD_WAIT: register the extracted result into mem_rdata, set mem_ready=1, go to IDLE.
REQ-021 Extraction: bytes selected by addr[1:0], halfwords by addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
REQ-022 Misaligned addresses SHALL NOT trap: LW/SW ignore addr[1:0], LH/LHU/SH ignore addr[0].
REQ-023 mem_ready and mem_rdata SHALL stay stable from assertion until the next mem_init.
REQ-024 Minimum read latency SHALL be 2 cycles from mem_init to mem_ready=1, with a same-cycle grant and rvalid one cycle later.
REQ-025 bus_req SHALL never be asserted in IDLE or RD_WAIT.
REQ-026 bus_rvalid outside RD_WAIT SHALL be ignored.
REQ-027 mem_write_op != SNONE outside IDLE is a protocol violation and SHALL be ignored.
REQ-028 mem_init in RD_REQ or RD_WAIT SHALL be ignored.

Reset
REQ-029 When reset_n=0 at an edge: state SHALL go to IDLE; the write buffer and pending read SHALL be cleared; bus_req=0, mem_ready=0, mem_rdata=0.
REQ-030 Reset mid-transaction SHALL abandon the transaction; a late bus_rvalid after reset SHALL be ignored.

Structure
REQ-031 LNONE/SNONE, the load/store encodings and the FSM state constants SHALL live in the shared defs include used by the core.
REQ-032 Load extraction and store lane placement SHALL be one combinational sub-module, mem_align.

Verification
REQ-033 LW at 0x100 with bus_rdata=0xDEADBEEF, grant immediate, rvalid +1 -> mem_ready=1 two cycles after mem_init, mem_rdata=0xDEADBEEF.
REQ-034 LB at 0x103, word 0x80112233 -> 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-035 SH 0x1234ABCD at 0x202 -> bus_addr=0x80, bus_wstrb=1100, bus_wdata=0xABCDABCD.
REQ-036 SW then mem_init on the next cycle, bus_gnt held low 3 cycles -> write granted first, read issued after, mem_ready=0 throughout the write.
REQ-037 reset_n=0 while in RD_WAIT, then bus_rvalid=1 -> mem_ready stays 0 and state stays IDLE.
